// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MAC-side XGMII transmit adapter:
// FSM state encoding, per-block control qualifiers and the keep split helper.
package mac_tx_pkg;

    localparam int DATA_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int KEEP_W  = DATA_W / 8;
    localparam int BKEEP_W = BLOCK_W / 8;

    // Byte 0 is overwritten with /S/ by the encoder downstream.
    localparam logic [BLOCK_W-1:0] PREAMBLE_BLOCK = 64'hD555_5555_5555_5555;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        TERM,
        IPG,
        DROP
    } tx_state_e;

    typedef struct packed {
        logic ctrl;
        logic idle;
        logic start;
        logic term;
        logic err;
    } blk_flags_t;

    localparam blk_flags_t FL_DATA  = 5'b00000;
    localparam blk_flags_t FL_IDLE  = 5'b11000;
    localparam blk_flags_t FL_START = 5'b10100;
    localparam blk_flags_t FL_TERM  = 5'b10010;
    localparam blk_flags_t FL_ERR   = 5'b10001;

    typedef struct packed {
        logic [KEEP_W-1:0] upper;
        logic [KEEP_W-1:0] lower;
    } keep_pair_t;

    function automatic keep_pair_t split_keep(input logic [BKEEP_W-1:0] keep);
        keep_pair_t kp;
        kp.lower = keep[KEEP_W-1:0];
        kp.upper = keep[BKEEP_W-1:KEEP_W];
        return kp;
    endfunction

endpackage

// File: rtl/mac_tx_keep_split.sv
// Splits a full-block byte-enable into the half currently on the wire and
// the half that shares its block.
module mac_tx_keep_split
    import mac_tx_pkg::*;
(
    input  logic [BKEEP_W-1:0] keep,
    input  logic               part,
    output logic [KEEP_W-1:0]  keep_cur,
    output logic [KEEP_W-1:0]  keep_other
);

    keep_pair_t kp;

    always_comb begin
        kp         = split_keep(keep);
        keep_cur   = part ? kp.upper : kp.lower;
        keep_other = part ? kp.lower : kp.upper;
    end

endmodule

// File: rtl/mac_tx_xgmii.sv
// 64-bit stream to 32-bit half-block adapter in front of the 10G PCS TX.
// Define MAC_TX_STATS_EN to add the frame_cnt_o / abort_cnt_o statistics ports.
module mac_tx_xgmii
    import mac_tx_pkg::*;
#(
    parameter int IPG_BLOCKS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_i,
    input  logic [BLOCK_W-1:0] s_data_i,
    input  logic [BKEEP_W-1:0] s_keep_i,
    input  logic               s_last_i,
    input  logic               s_err_i,
    output logic               s_ready_o,
    input  logic               pcs_ready_i,
    output logic               ctrl_v_o,
    output logic               idle_v_o,
    output logic               start_o,
    output logic               term_o,
    output logic               err_o,
    output logic               part_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [KEEP_W-1:0]  keep_o,
    output logic [KEEP_W-1:0]  keep_next_o
`ifdef MAC_TX_STATS_EN
    ,
    output logic [31:0]        frame_cnt_o,
    output logic [15:0]        abort_cnt_o
`endif
);

    localparam logic [3:0] IPG_CNT = 4'(IPG_BLOCKS);

    tx_state_e          state_q, state_d;
    logic               part_q;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    blk_flags_t         flags_q, flags_d;
    logic [BKEEP_W-1:0] bkeep_q, bkeep_d;
    logic [3:0]         ipg_cnt_q, ipg_cnt_d;
    logic               last_seen_q, err_seen_q;
    logic               boundary, accept, frame_err;

    assign boundary  = pcs_ready_i & part_q;
    assign s_ready_o = (((state_q == PRE || state_q == DATA) && boundary) || state_q == DROP)
                       && !last_seen_q;
    assign accept    = s_valid_i & s_ready_o;
    // Only consulted when the beat on the stream is being accepted.
    assign frame_err = err_seen_q | s_err_i;

    // Decides the next block; the registers only load it at a boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        buf_d     = '0;
        flags_d   = FL_IDLE;
        bkeep_d   = '0;
        ipg_cnt_d = ipg_cnt_q;
        case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    state_d = PRE;
                    buf_d   = PREAMBLE_BLOCK;
                    flags_d = FL_START;
                    bkeep_d = '1;
                end
            end
            PRE, DATA: begin
                if (last_seen_q) begin
                    if (flags_q.ctrl) begin
                        state_d   = IPG;
                        ipg_cnt_d = 4'd1;
                    end else begin
                        state_d = TERM;
                        flags_d = err_seen_q ? FL_ERR : FL_TERM;
                    end
                end else if (s_valid_i) begin
                    state_d = DATA;
                    buf_d   = s_data_i;
                    if (s_last_i && s_keep_i != '1) begin
                        flags_d = frame_err ? FL_ERR : FL_TERM;
                        bkeep_d = frame_err ? '0 : s_keep_i;
                    end else begin
                        flags_d = FL_DATA;
                        bkeep_d = s_keep_i;
                    end
                end else begin
                    state_d = DROP;
                    flags_d = FL_ERR;
                end
            end
            TERM: begin
                state_d   = IPG;
                ipg_cnt_d = 4'd1;
            end
            IPG: begin
                if (ipg_cnt_q >= IPG_CNT) state_d = IDLE;
                else ipg_cnt_d = ipg_cnt_q + 4'd1;
            end
            DROP: begin
                if (last_seen_q || (accept && s_last_i)) begin
                    state_d   = IPG;
                    ipg_cnt_d = 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            part_q      <= 1'b0;
            buf_q       <= '0;
            flags_q     <= FL_IDLE;
            bkeep_q     <= '0;
            ipg_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            err_seen_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (s_last_i) last_seen_q <= 1'b1;
                if (s_err_i)  err_seen_q  <= 1'b1;
            end
            if (pcs_ready_i) part_q <= ~part_q;
            if (boundary) begin
                state_q   <= state_d;
                buf_q     <= buf_d;
                flags_q   <= flags_d;
                bkeep_q   <= bkeep_d;
                ipg_cnt_q <= ipg_cnt_d;
                if (state_d == PRE) begin
                    last_seen_q <= 1'b0;
                    err_seen_q  <= 1'b0;
                end
            end
        end
    end

    assign part_o = part_q;
    assign data_o = part_q ? buf_q[BLOCK_W-1:DATA_W] : buf_q[DATA_W-1:0];
    assign {ctrl_v_o, idle_v_o, start_o, term_o, err_o} = flags_q;

    mac_tx_keep_split u_keep_split (
        .keep       (bkeep_q),
        .part       (part_q),
        .keep_cur   (keep_o),
        .keep_other (keep_next_o)
    );

`ifdef MAC_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_o <= '0;
            abort_cnt_o <= '0;
        end else if (boundary) begin
            if (flags_d.term) frame_cnt_o <= frame_cnt_o + 32'd1;
            if (flags_d.err)  abort_cnt_o <= abort_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_tx_xgmii.sv
// Scoreboard bench for mac_tx_xgmii: directed frames push expected half-blocks,
// a negedge monitor pops and compares whatever the PCS side consumes.
module tb_mac_tx_xgmii;

    localparam logic [4:0] F_DATA  = 5'b00000;
    localparam logic [4:0] F_IDLE  = 5'b11000;
    localparam logic [4:0] F_START = 5'b10100;
    localparam logic [4:0] F_TERM  = 5'b10010;
    localparam logic [4:0] F_ERR   = 5'b10001;
    localparam logic [63:0] PREAMBLE = 64'hD555_5555_5555_5555;

    localparam logic [63:0] BEAT_TAB [13] = '{
        64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908, 64'h1716_1514_1312_1110,
        64'hA1A2_A3A4_A5A6_A7A8, 64'hB1B2_B3B4_B5B6_B7B8,
        64'hC0C1_C2C3_C4C5_C6C7, 64'hC8C9_CACB_CCCD_CECF, 64'hD0D1_D2D3_D4D5_D6D7,
        64'hD8D9_DADB_DCDD_DEDF,
        64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
        64'hDEAD_BEEF_CAFE_F00D
    };

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  keep_next;
        logic        chk_data;
        logic        chk_keep;
        logic        skip;
    } item_t;

    logic        clk, reset;
    logic        s_valid_i, s_last_i, s_err_i, s_ready_o, pcs_ready_i;
    logic [63:0] s_data_i;
    logic [7:0]  s_keep_i;
    logic        ctrl_v_o, idle_v_o, start_o, term_o, err_o, part_o;
    logic [31:0] data_o;
    logic [3:0]  keep_o, keep_next_o;
`ifdef MAC_TX_STATS_EN
    logic [31:0] frame_cnt_o;
    logic [15:0] abort_cnt_o;
`endif

    item_t exp_q [$];
    int    checks = 0;
    int    failures = 0;
    bit    mon_en = 1'b0;
    bit    exp_part = 1'b0;

    mac_tx_xgmii #(.IPG_BLOCKS(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_keep_i    (s_keep_i),
        .s_last_i    (s_last_i),
        .s_err_i     (s_err_i),
        .s_ready_o   (s_ready_o),
        .pcs_ready_i (pcs_ready_i),
        .ctrl_v_o    (ctrl_v_o),
        .idle_v_o    (idle_v_o),
        .start_o     (start_o),
        .term_o      (term_o),
        .err_o       (err_o),
        .part_o      (part_o),
        .data_o      (data_o),
        .keep_o      (keep_o),
        .keep_next_o (keep_next_o)
`ifdef MAC_TX_STATS_EN
        ,
        .frame_cnt_o (frame_cnt_o),
        .abort_cnt_o (abort_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void push_block(input logic [4:0] fl, input logic [63:0] d, input logic [7:0] k,
                                       input bit cd, input bit ck, input bit skip);
        item_t lo, hi;
        lo.flags = fl;     lo.data = d[31:0];  lo.keep = k[3:0]; lo.keep_next = k[7:4];
        lo.chk_data = cd;  lo.chk_keep = ck;   lo.skip = skip;
        hi = lo;
        hi.data = d[63:32]; hi.keep = k[7:4]; hi.keep_next = k[3:0]; hi.skip = 1'b0;
        exp_q.push_back(lo);
        exp_q.push_back(hi);
    endfunction

    task automatic check_reset_outputs();
        check("rst_s_ready", s_ready_o, 0);
        check("rst_flags", {ctrl_v_o, idle_v_o, start_o, term_o, err_o}, F_IDLE);
        check("rst_part", part_o, 0);
        check("rst_data", data_o, 0);
        check("rst_keep", {keep_o, keep_next_o}, 0);
`ifdef MAC_TX_STATS_EN
        check("rst_stats", {frame_cnt_o, abort_cnt_o}, 0);
`endif
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last, input logic err);
        bit got = 1'b0;
        s_valid_i = 1'b1; s_data_i = d; s_keep_i = k; s_last_i = last; s_err_i = err;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = s_ready_o;
        end
        check("beat_accept", got, 1);
        @(posedge clk); #1;
        s_valid_i = 1'b0; s_last_i = 1'b0; s_err_i = 1'b0;
    endtask

    // gap_after >= 0 starves the stream after that beat (underrun);
    // stall_after >= 0 drops pcs_ready for the second half of the next block.
    task automatic run_frame(input int first, input int n, input logic [7:0] last_keep, input int err_at,
                             input int gap_after, input int stall_after, input bit lead_idle, input bit skip);
        bit err_frame = (err_at >= 0);
        if (lead_idle) push_block(F_IDLE, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        push_block(F_START, PREAMBLE, 8'hFF, 1'b1, 1'b1, skip);
        if (gap_after >= 0) begin
            for (int i = 0; i <= gap_after; i++)
                push_block(F_DATA, BEAT_TAB[first+i], 8'hFF, 1'b1, 1'b1, 1'b0);
            push_block(F_ERR, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < n - 1; i++)
                push_block(F_DATA, BEAT_TAB[first+i], 8'hFF, 1'b1, 1'b1, 1'b0);
            if (last_keep == 8'hFF) begin
                push_block(F_DATA, BEAT_TAB[first+n-1], 8'hFF, 1'b1, 1'b1, 1'b0);
                push_block(err_frame ? F_ERR : F_TERM, 64'h0, 8'h00, 1'b0, !err_frame, 1'b0);
            end else begin
                push_block(err_frame ? F_ERR : F_TERM, BEAT_TAB[first+n-1], last_keep,
                           !err_frame, !err_frame, 1'b0);
            end
            push_block(F_IDLE, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            send_beat(BEAT_TAB[first+i], (i == n - 1) ? last_keep : 8'hFF, i == n - 1, i == err_at);
            if (i == stall_after) begin
                fork
                    begin
                        @(posedge clk); #1 pcs_ready_i = 1'b0;
                        @(posedge clk); #1 pcs_ready_i = 1'b1;
                    end
                join_none
            end
            if (i == gap_after) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : monitor
        item_t it;
        logic [4:0] fl;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_part = 1'b0;
                continue;
            end
            if (!mon_en) continue;
            fl = {ctrl_v_o, idle_v_o, start_o, term_o, err_o};
            check("part", part_o, exp_part);
            if (!pcs_ready_i) check("s_ready_stall", s_ready_o, 0);
            if (exp_q.size() == 0) begin
                check("idle_flags", fl, F_IDLE);
            end else begin
                it = exp_q[0];
                if (!(it.skip && fl == F_IDLE)) begin
                    check("flags", fl, it.flags);
                    if (it.chk_data) check("data", data_o, it.data);
                    if (it.chk_keep) begin
                        check("keep", keep_o, it.keep);
                        check("keep_next", keep_next_o, it.keep_next);
                    end
                    if (pcs_ready_i) void'(exp_q.pop_front());
                end
            end
            if (pcs_ready_i) exp_part = ~exp_part;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        reset = 1'b1; pcs_ready_i = 1'b1;
        s_valid_i = 1'b0; s_data_i = '0; s_keep_i = '0; s_last_i = 1'b0; s_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        run_frame(0,  3, 8'h0F, -1, -1, -1, 1'b0, 1'b1);
        run_frame(3,  2, 8'hFF, -1, -1,  0, 1'b1, 1'b0);
        run_frame(5,  4, 8'hFF, -1,  0, -1, 1'b1, 1'b0);
        run_frame(9,  3, 8'h3F,  1, -1, -1, 1'b0, 1'b1);
        run_frame(12, 1, 8'h01, -1, -1, -1, 1'b1, 1'b0);

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 0);
        repeat (10) @(posedge clk);
        #1;
`ifdef MAC_TX_STATS_EN
        check("frame_cnt", frame_cnt_o, 3);
        check("abort_cnt", abort_cnt_o, 2);
`endif

        mon_en = 1'b0;
        send_beat(BEAT_TAB[0], 8'hFF, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
